// File: rtl/ahb_lite_mem_slave_if.sv
// AHB-Lite bus bundle between one master (or the bench) and the memory slave.
`timescale 1ns/1ps

interface ahb_lite_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [1:0]            HTRANS;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave: byte-lane writes, programmable wait states,
// two-cycle ERROR response and write-to-read forwarding.
`timescale 1ns/1ps

module ahb_lite_mem_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input logic                 HCLK,
  input logic                 HRESETn,
  ahb_lite_mem_slave_if.slave bus
);

  localparam int          BYTES     = DATA_WIDTH / 8;
  localparam int          LANE_BITS = $clog2(BYTES);
  localparam int          IDX_BITS  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t state, next_state;

  logic                  hreadyout, hresp;
  logic [2:0]            cnt_q;
  logic                  write_q;
  logic [BYTES-1:0]      be_q;
  logic [IDX_BITS-1:0]   idx_q;
  logic [DATA_WIDTH-1:0] hrdata_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Address-phase decode
  logic [ADDR_WIDTH-1:0] offset;
  logic [LANE_BITS-1:0]  lane;
  logic [IDX_BITS-1:0]   acc_idx;
  logic [BYTES-1:0]      acc_be;
  logic [2:0]            align_mask;
  logic                  range_err, size_err, align_err, xfer_err, accept;

  assign offset    = bus.HADDR - BASE_ADDR;
  assign lane      = bus.HADDR[LANE_BITS-1:0];
  assign acc_idx   = IDX_BITS'(offset >> LANE_BITS);
  assign range_err = (bus.HADDR < BASE_ADDR) || (64'(offset) >= MEM_BYTES);
  assign size_err  = bus.HSIZE > 3'(LANE_BITS);
  assign align_err = (bus.HADDR[2:0] & align_mask) != 3'b000;
  assign xfer_err  = range_err || size_err || align_err;
  // Address inputs only count while the slave itself is ready.
  assign accept    = bus.HSEL && bus.HREADY && bus.HTRANS[1] && hreadyout;

  // Low-address bits that must be zero for the requested size.
  // NOTE: every variable written in a combinational block gets a default first,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    align_mask = 3'b111;
    case (bus.HSIZE)
      3'd0:    align_mask = 3'b000;
      3'd1:    align_mask = 3'b001;
      3'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  // Byte lanes touched by the accepted transfer (little-endian).
  always_comb begin
    acc_be = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (b >= int'(lane) && b < int'(lane) + (1 << bus.HSIZE))
        acc_be[b] = 1'b1;
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated in.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state logic; IDLE, LAST and ERR2 can all take a new address phase.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE, ST_LAST, ST_ERR2: begin
        if (!accept)          next_state = ST_IDLE;
        else if (xfer_err)    next_state = ST_ERR1;
        else if (WAIT_STATES == 0) next_state = ST_LAST;
        else                  next_state = ST_WAIT;
      end
      ST_WAIT: if (cnt_q == 3'd0) next_state = ST_LAST;
      ST_ERR1: next_state = ST_ERR2;
      default: next_state = ST_IDLE;
    endcase
  end

  // Response outputs are a pure function of the state.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    unique case (state)
      ST_WAIT: hreadyout = 1'b0;
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
      default: ;
    endcase
  end

  // Capture the accepted address phase and run the wait-state counter.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      cnt_q   <= 3'd0;
      write_q <= 1'b0;
      be_q    <= '0;
      idx_q   <= '0;
    end else if (accept) begin
      cnt_q   <= (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
      write_q <= bus.HWRITE;
      be_q    <= acc_be;
      idx_q   <= acc_idx;
    end else if (state == ST_WAIT && cnt_q != 3'd0) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  // Write data is taken on the edge that ends LAST.
  logic wr_commit;
  assign wr_commit = (state == ST_LAST) && write_q;

  // Read word selection, with bytes of a same-edge write merged in.
  logic [IDX_BITS-1:0]   rd_idx;
  logic                  rd_load;
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    rd_idx  = idx_q;
    rd_load = 1'b0;
    if (state == ST_WAIT) begin
      rd_load = (next_state == ST_LAST) && !write_q;
    end else if (next_state == ST_LAST) begin
      rd_idx  = acc_idx;
      rd_load = !bus.HWRITE;
    end
    rd_word = mem[rd_idx];
    if (wr_commit && idx_q == rd_idx) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be_q[b]) rd_word[8*b +: 8] = bus.HWDATA[8*b +: 8];
      end
    end
  end

  // Read data register, held until the next read load.
  always_ff @(posedge HCLK) begin
    if (!HRESETn)     hrdata_q <= '0;
    else if (rd_load) hrdata_q <= rd_word;
  end

  // Memory array write port.
  // NOTE: the array is intentionally left out of reset: contents survive reset
  // and a reset branch would stop the array mapping onto a RAM.
  always_ff @(posedge HCLK) begin
    if (HRESETn && wr_commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = hrdata_q;

  // Burst type and the BUSY/SEQ distinction carry no meaning for this slave.
  logic unused_bits;
  assign unused_bits = ^{bus.HBURST, bus.HTRANS[0], offset};

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Bench for ahb_lite_mem_slave: one zero-wait and one three-wait instance
// share master signals; HSEL picks the target. A scoreboard queue per slave
// holds the expected response of each address phase until its data phase ends.
`timescale 1ns/1ps

module tb_ahb_lite_mem_slave;

  localparam int AW = 32;
  localparam int DW = 32;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  logic          sel0, sel1;
  logic [AW-1:0] m_addr;
  logic          m_write;
  logic [2:0]    m_size;
  logic [1:0]    m_trans;
  logic [DW-1:0] m_wdata;

  ahb_lite_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  ahb_lite_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  assign bus0.HSEL   = sel0;
  assign bus0.HADDR  = m_addr;
  assign bus0.HWRITE = m_write;
  assign bus0.HSIZE  = m_size;
  assign bus0.HBURST = 3'b000;
  assign bus0.HTRANS = m_trans;
  assign bus0.HWDATA = m_wdata;
  assign bus0.HREADY = bus0.HREADYOUT;

  assign bus1.HSEL   = sel1;
  assign bus1.HADDR  = m_addr;
  assign bus1.HWRITE = m_write;
  assign bus1.HSIZE  = m_size;
  assign bus1.HBURST = 3'b001;
  assign bus1.HTRANS = m_trans;
  assign bus1.HWDATA = m_wdata;
  assign bus1.HREADY = bus1.HREADYOUT;

  ahb_lite_mem_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(256),
    .BASE_ADDR(32'h0), .WAIT_STATES(0)
  ) u_ws0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0)
  );

  ahb_lite_mem_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(256),
    .BASE_ADDR(32'h0), .WAIT_STATES(3)
  ) u_ws3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus1)
  );

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        idle_after;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct packed {
    logic [15:0] id;
    logic        rd;
    logic        err;
    logic [31:0] data;
    logic [3:0]  waits;
  } exp_t;

  vec_t vecs[$];
  exp_t q0[$];
  exp_t q1[$];

  int total = 0;
  int bad   = 0;

  bit dp[2];
  int nwait[2];
  int nresp[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                              input logic [31:0] wdata, input logic idle_after,
                              input logic err, input logic [31:0] rdata);
    vec_t v;
    v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata;
    v.idle_after = idle_after; v.err = err; v.rdata = rdata;
    return v;
  endfunction

  task automatic push_exp(input int d, input int id, input logic rd, input logic err,
                          input logic [31:0] data);
    exp_t e;
    e.id    = 16'(id);
    e.rd    = rd;
    e.err   = err;
    e.data  = data;
    e.waits = err ? 4'd1 : ((d == 0) ? 4'd0 : 4'd3);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Completes a data phase when HREADYOUT is high; counts stalled cycles before it.
  task automatic mon_step(input int d, input logic rdy, input logic resp,
                          input logic [31:0] rdata, input logic sel);
    exp_t e;
    int   depth;
    if (dp[d]) begin
      if (!rdy) begin
        nwait[d]++;
        if (resp) nresp[d]++;
      end else begin
        depth = (d == 0) ? q0.size() : q1.size();
        if (depth == 0) begin
          check($sformatf("dut%0d_unexpected_xfer", d), 32'd1, 32'd0);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check($sformatf("dut%0d_x%0d_waits", d, e.id), 32'(nwait[d]), 32'(e.waits));
          check($sformatf("dut%0d_x%0d_hresp", d, e.id), 32'(resp), 32'(e.err));
          check($sformatf("dut%0d_x%0d_resp_cycles", d, e.id), 32'(nresp[d]),
                e.err ? 32'd1 : 32'd0);
          if (e.rd && !e.err)
            check($sformatf("dut%0d_x%0d_hrdata", d, e.id), rdata, e.data);
        end
        nwait[d] = 0;
        nresp[d] = 0;
      end
    end
    if (rdy) dp[d] = sel && m_trans[1];
  endtask

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < 2; i++) begin
        dp[i]    = 1'b0;
        nwait[i] = 0;
        nresp[i] = 0;
      end
      q0.delete();
      q1.delete();
    end else begin
      mon_step(0, bus0.HREADYOUT, bus0.HRESP, bus0.HRDATA, sel0);
      mon_step(1, bus1.HREADYOUT, bus1.HRESP, bus1.HRDATA, sel1);
    end
  end

  task automatic wait_ready(input int d);
    logic rdy;
    for (int i = 0; i < 32; i++) begin
      @(negedge HCLK);
      rdy = (d == 0) ? bus0.HREADYOUT : bus1.HREADYOUT;
      if (rdy === 1'b1) return;
    end
    check($sformatf("dut%0d_ready_timeout", d), 32'd0, 32'd1);
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  // with this transfer's write data on the bus.
  task automatic xfer(input int d, input int id, input logic wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata,
                      input logic err, input logic [31:0] rdata);
    sel0    = (d == 0);
    sel1    = (d == 1);
    m_addr  = addr;
    m_write = wr;
    m_size  = size;
    m_trans = 2'b10;
    push_exp(d, id, !wr, err, rdata);
    wait_ready(d);
    @(posedge HCLK);
    #1;
    m_wdata = wr ? wdata : 32'h0;
  endtask

  task automatic bus_idle(input int d);
    sel0    = 1'b0;
    sel1    = 1'b0;
    m_trans = 2'b00;
    wait_ready(d);
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESETn = 1'b0;
    sel0 = 1'b0; sel1 = 1'b0;
    m_addr = '0; m_write = 1'b0; m_size = 3'd0; m_trans = 2'b00; m_wdata = '0;

    //                wr    addr          sz    wdata         idle  err   rdata
    vecs.push_back(mk(1'b1, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 32'h0000_0010, 3'd2, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF));
    vecs.push_back(mk(1'b1, 32'h0000_0020, 3'd2, 32'h1122_3344, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 32'h0000_0020, 3'd2, 32'h0,         1'b1, 1'b0, 32'h1122_3344));
    vecs.push_back(mk(1'b1, 32'h0000_0021, 3'd0, 32'h0000_AA00, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 32'h0000_0020, 3'd2, 32'h0,         1'b1, 1'b0, 32'h1122_AA44));
    vecs.push_back(mk(1'b1, 32'h0000_0000, 3'd2, 32'h0102_0304, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 32'h0000_0400, 3'd2, 32'h0,         1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b1, 32'h0000_0001, 3'd1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b1, 32'h0000_0020, 3'd3, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b1, 32'h0000_0022, 3'd2, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 32'h0000_0020, 3'd2, 32'h0,         1'b1, 1'b0, 32'h1122_AA44));
    vecs.push_back(mk(1'b1, 32'h0000_0012, 3'd1, 32'hBEEF_0000, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 32'h0000_0010, 3'd2, 32'h0,         1'b1, 1'b0, 32'hBEEF_BEEF));
    vecs.push_back(mk(1'b1, 32'h0000_03FC, 3'd2, 32'h0000_0000, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 32'h0000_03FF, 3'd0, 32'h5A00_0000, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 32'h0000_03FC, 3'd2, 32'h0,         1'b1, 1'b0, 32'h5A00_0000));
    vecs.push_back(mk(1'b0, 32'h0000_0000, 3'd2, 32'h0,         1'b1, 1'b0, 32'h0102_0304));
    vecs.push_back(mk(1'b0, 32'hFFFF_FFFC, 3'd2, 32'h0,         1'b1, 1'b1, 32'h0));

    // Reset state.
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_ws0_hreadyout", 32'(bus0.HREADYOUT), 32'd1);
    check("rst_ws0_hresp",     32'(bus0.HRESP),     32'd0);
    check("rst_ws0_hrdata",    bus0.HRDATA,         32'd0);
    check("rst_ws3_hreadyout", 32'(bus1.HREADYOUT), 32'd1);
    check("rst_ws3_hresp",     32'(bus1.HRESP),     32'd0);
    check("rst_ws3_hrdata",    bus1.HRDATA,         32'd0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Table of zero-wait transfers, pipelined unless a bubble is requested.
    foreach (vecs[i]) begin
      xfer(0, i, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata,
           vecs[i].err, vecs[i].rdata);
      if (vecs[i].idle_after) bus_idle(0);
    end
    bus_idle(0);

    // BUSY with HSEL=1, then NONSEQ with HSEL=0: neither is a transfer.
    sel0 = 1'b1; m_write = 1'b1; m_addr = 32'h10; m_size = 3'd2;
    m_trans = 2'b01; m_wdata = 32'hFFFF_FFFF;
    @(posedge HCLK);
    #1;
    @(negedge HCLK);
    check("busy_hreadyout", 32'(bus0.HREADYOUT), 32'd1);
    check("busy_hresp",     32'(bus0.HRESP),     32'd0);
    sel0 = 1'b0;
    m_trans = 2'b10;
    @(posedge HCLK);
    #1;
    @(negedge HCLK);
    check("unsel_hreadyout", 32'(bus0.HREADYOUT), 32'd1);
    check("unsel_hresp",     32'(bus0.HRESP),     32'd0);
    m_trans = 2'b00;
    @(posedge HCLK);
    #1;
    xfer(0, 100, 1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 32'hBEEF_BEEF);
    bus_idle(0);

    // Three wait states: seed two words.
    xfer(1, 200, 1'b1, 32'h40, 3'd2, 32'hCAFE_F00D, 1'b0, 32'h0);
    xfer(1, 201, 1'b1, 32'h34, 3'd2, 32'h3434_3434, 1'b0, 32'h0);
    bus_idle(1);

    // Write with a stray address phase held during two of its wait cycles.
    xfer(1, 202, 1'b1, 32'h30, 3'd2, 32'h0BAD_F00D, 1'b0, 32'h0);
    sel1 = 1'b1; m_addr = 32'h34; m_write = 1'b1; m_size = 3'd0; m_trans = 2'b10;
    @(posedge HCLK);
    #1;
    @(posedge HCLK);
    #1;
    bus_idle(1);

    xfer(1, 203, 1'b0, 32'h30, 3'd2, 32'h0, 1'b0, 32'h0BAD_F00D);
    xfer(1, 204, 1'b0, 32'h34, 3'd2, 32'h0, 1'b0, 32'h3434_3434);
    xfer(1, 205, 1'b0, 32'h40, 3'd2, 32'h0, 1'b0, 32'hCAFE_F00D);
    bus_idle(1);

    // Reset in the second wait cycle of a write abandons it.
    xfer(1, 206, 1'b1, 32'h40, 3'd2, 32'h1234_5678, 1'b0, 32'h0);
    sel1 = 1'b0;
    m_trans = 2'b00;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b0;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("abort_ws3_hreadyout", 32'(bus1.HREADYOUT), 32'd1);
    check("abort_ws3_hresp",     32'(bus1.HRESP),     32'd0);
    check("abort_ws3_hrdata",    bus1.HRDATA,         32'd0);
    check("abort_ws0_hrdata",    bus0.HRDATA,         32'd0);
    @(posedge HCLK);
    #1;
    xfer(1, 207, 1'b0, 32'h40, 3'd2, 32'h0, 1'b0, 32'hCAFE_F00D);
    bus_idle(1);
    xfer(0, 101, 1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 32'hBEEF_BEEF);
    bus_idle(0);

    repeat (2) @(posedge HCLK);
    check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
